fetch_decode_queue: RTL and testbench

- Parametrised successor to the single-entry fetch/decode pipeline register.
- Provides a DEPTH-entry in-order instruction queue between the fetch stage and the decode stage.
- Uses valid/ready handshakes on both sides, a flush input for branch mispredict or redirect, and a predicted-taken tag carried with each instruction.
- Decouples fetch from decode stalls, so fetch keeps running until the queue is full.

---
 rtl/fetch_decode_queue.sv | 93 +++++++++
 tb/tb_fetch_decode_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry in-order fetch->decode instruction queue with valid/ready on both sides and flush.
// Define FDQ_BYPASS_EN to let an empty queue forward the fetch entry combinationally to decode.
module fetch_decode_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr_f,
  input  logic [DATA_W-1:0] pc_plus_4_f,
  input  logic              pred_taken_f,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] instr_d,
  output logic [DATA_W-1:0] pc_plus_4_d,
  output logic              pred_taken_d,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic              tag_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full, q_valid, bypass;
  logic             push, pop, wr_en, rd_en;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign q_valid  = (cnt != '0);
  assign in_ready = !full;
  assign count    = cnt;

  always_comb begin
    bypass = 1'b0;
`ifdef FDQ_BYPASS_EN
    bypass = (cnt == '0) && !flush;
`endif
  end

  assign out_valid = bypass ? in_valid : q_valid;
  assign push      = in_valid & in_ready & !flush;
  assign pop       = out_valid & out_ready & !flush;
  // A bypassed entry consumed by decode is never written; it counts as neither push nor pop.
  assign wr_en     = push & !(bypass & pop);
  assign rd_en     = pop & !bypass;

  always_comb begin
    instr_d      = '0;
    pc_plus_4_d  = '0;
    pred_taken_d = 1'b0;
    if (bypass && in_valid) begin
      instr_d      = instr_f;
      pc_plus_4_d  = pc_plus_4_f;
      pred_taken_d = pred_taken_f;
    end else if (q_valid) begin
      instr_d      = instr_mem[rd_ptr];
      pc_plus_4_d  = pc_mem[rd_ptr];
      pred_taken_d = tag_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      instr_mem[wr_ptr] <= instr_f;
      pc_mem[wr_ptr]    <= pc_plus_4_f;
      tag_mem[wr_ptr]   <= pred_taken_f;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_fetch_decode_queue;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, pred_taken_f;
  logic [DATA_W-1:0] instr_f, pc_plus_4_f;
  logic              out_valid, out_ready, pred_taken_d;
  logic [DATA_W-1:0] instr_d, pc_plus_4_d;
  logic [CNT_W-1:0]  count;

  fetch_decode_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_f(instr_f), .pc_plus_4_f(pc_plus_4_f), .pred_taken_f(pred_taken_f),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_d(instr_d), .pc_plus_4_d(pc_plus_4_d), .pred_taken_d(pred_taken_d),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] i;
    logic [DATA_W-1:0] p;
    logic              t;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

`ifdef FDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of entries updated from the handshake rules.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      bit was_full, can_pop, take_bypass;
      was_full    = (q.size() == DEPTH);
      take_bypass = BYP && q.size() == 0 && in_valid && out_ready;
      can_pop     = (q.size() != 0) && out_ready;
      if (!take_bypass) begin
        if (can_pop) void'(q.pop_front());
        if (in_valid && !was_full) q.push_back('{instr_f, pc_plus_4_f, pred_taken_f});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      ent_t e;
      logic ev;
      e  = '0;
      ev = (q.size() != 0);
      if (q.size() != 0) e = q[0];
      else if (BYP && !flush && in_valid) begin
        ev = 1'b1;
        e  = '{instr_f, pc_plus_4_f, pred_taken_f};
      end
      chk("model_out_valid", 64'(out_valid), 64'(ev));
      chk("model_in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      chk("model_count", 64'(count), 64'(q.size()));
      chk("model_instr", 64'(instr_d), 64'(e.i));
      chk("model_pc4", 64'(pc_plus_4_d), 64'(e.p));
      chk("model_tag", 64'(pred_taken_d), 64'(e.t));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic t, input logic r);
    in_valid = v; instr_f = i; pc_plus_4_f = p; pred_taken_f = t; out_ready = r;
  endtask

  logic [31:0] ei [4];
  logic        et [4];

  initial begin
    ei[0] = 32'h00A00093; ei[1] = 32'h00100113; ei[2] = 32'h00200193; ei[3] = 32'h00300213;
    et[0] = 1'b0;         et[1] = 1'b1;         et[2] = 1'b0;         et[3] = 1'b1;
    rst_n = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h11111111, 32'h4, 1'b1, 1'b1);
    step(); step();
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk_en = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_instr", 64'(instr_d), 64'd0);
    chk("rst_pc4", 64'(pc_plus_4_d), 64'd0);
    chk("rst_tag", 64'(pred_taken_d), 64'd0);
    step();

    // Fill with decode stalled; head must stay the first instruction.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ei[k], 32'(4 * (k + 1)), et[k], 1'b0);
      step();
      chk("fill_head", 64'(instr_d), 64'h00A00093);
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'hBADBAD00, 32'h14, 1'b1, 1'b0);
    step(); step();
    chk("full_hold_count", 64'(count), 64'd4);
    chk("full_hold_head", 64'(instr_d), 64'h00A00093);

    // Drain in order with tags.
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_instr", 64'(instr_d), 64'(ei[k]));
      chk("drain_pc4", 64'(pc_plus_4_d), 64'(4 * (k + 1)));
      chk("drain_tag", 64'(pred_taken_d), 64'(et[k]));
      step();
    end
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_instr", 64'(instr_d), 64'd0);

    // Count=2, simultaneous push/pop across pointer wrap.
    drive(1'b1, 32'hAAAA0001, 32'h100, 1'b1, 1'b0); step();
    drive(1'b1, 32'hAAAA0002, 32'h104, 1'b0, 1'b0); step();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h00001000 + 32'(k), 32'h200 + 32'(4 * k), k[0], 1'b1);
      #1;
      chk("pp_count", 64'(count), 64'd2);
      chk("pp_head", 64'(instr_d),
          (k == 0) ? 64'hAAAA0001 : (k == 1) ? 64'hAAAA0002 : 64'(32'h1000 + 32'(k - 2)));
      step();
    end
    chk("pp_after_count", 64'(count), 64'd2);

    // Grow to 3, then flush with a simultaneous push and pop.
    drive(1'b1, 32'h0000CAFE, 32'h300, 1'b0, 1'b0); step();
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 32'h400, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    step();
    drive(1'b1, 32'h0BADF00D, 32'h500, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("post_flush_head", 64'(instr_d), 64'h0BADF00D);
    drive(1'b0, '0, '0, 1'b0, 1'b1); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0); step();
    chk("post_flush_empty", 64'(count), 64'd0);

    // Empty queue, push and pop in the same cycle: bypass vs one-cycle latency.
    drive(1'b1, 32'h12345678, 32'h20, 1'b1, 1'b1);
    #1;
    chk("byp_same_instr", 64'(instr_d), BYP ? 64'h12345678 : 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("byp_next_instr", 64'(instr_d), BYP ? 64'd0 : 64'h12345678);
    chk("byp_next_count", 64'(count), BYP ? 64'd0 : 64'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b1); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0); step();

    // Reset mid-stream with traffic still presented.
    drive(1'b1, 32'h77770001, 32'h600, 1'b1, 1'b0); step();
    drive(1'b1, 32'h77770002, 32'h604, 1'b0, 1'b0); step();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_instr", 64'(instr_d), 64'd0);
    step(); step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
